ifft_conj_post_16b: RTL and testbench
=====================================

// Module: ifft_conj_post_16b
// PURPOSE
//  Output-side companion of the input sign-inversion path for inverse FFT.
//  The IFFT runs as conj(FFT(conj(x)))/N. This block sits after the FFT core
//  and applies the final conjugation (imaginary negation) and the 1/N scaling.
//  It is a 2-stage valid/ready pipeline with frame counting and frame-error
//  detection.
// PARAMETERS
//  N_POINTS   64  samples per frame; power of two, 2..1024
//  SHIFT      6   arithmetic right shift for 1/N; 0..15; normally log2(N_POINTS)
//  BYPASS     0   1 = forward FFT mode: pass data unchanged, keep handshake and counting
// PORTS
//  clk        in   1   clock; all logic on the rising edge
//  rst        in   1   synchronous, active-high reset
//  i_re       in   16  input real, two's complement
//  i_im       in   16  input imaginary, two's complement
//  i_valid    in   1   input sample valid
//  i_last     in   1   FFT core marks the final sample of a frame
//  o_ready    out  1   block can accept an input sample
//  o_re       out  16  output real
//  o_im       out  16  output imaginary
//  o_valid    out  1   output sample valid
//  o_last     out  1   final sample of a frame, generated from the internal count
//  i_ready    in   1   downstream accepts the output sample
//  o_frm_err  out  1   sticky flag: i_last was misplaced
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): all outputs go to 0 except o_ready, which goes to 1.
//   Both pipe stages empty; sample count = 0; o_frm_err = 0.
//  Handshake
//   - Input transfer occurs when i_valid & o_ready.
//   - Output transfer occurs when o_valid & i_ready.
//   - o_re, o_im and o_last hold stable while o_valid & !i_ready.
//   - o_ready = !(stage1 full & stage2 full & !i_ready). It is a registered
//     pipeline; no combinational path from i_valid to o_valid.
//   - Latency is 2 cycles from input transfer to o_valid when not stalled.
//   - Throughput is 1 sample/cycle with i_ready held high.
//  Stage 1 (conjugate)
//   - re1 = i_re.
//   - im1 = -i_im, computed as two's complement (~i_im + 1).
//   - Saturation: i_im = 16'h8000 gives im1 = 16'h7FFF.
//  Stage 2 (scale)
//   - o_x = (x1 + (1 << (SHIFT-1))) >>> SHIFT, using a 17-bit intermediate,
//     rounding half up.
//   - The result is clamped to [-32768, 32767].
//   - SHIFT = 0 applies no rounding and no shift.
//  BYPASS=1: o_re = i_re and o_im = i_im with no negation or scaling.
//   Latency stays 2 cycles.
//  Frame counter
//   - cnt increments on each input transfer.
//   - It wraps N_POINTS-1 -> 0.
//   - The sample accepted with cnt = N_POINTS-1 carries o_last = 1.
//  Frame error
//   - On an input transfer, i_last != (cnt == N_POINTS-1) sets o_frm_err.
//   - o_frm_err is cleared only by rst.
//   - Data flow and counting continue unaffected; the counter is not resynced.
//  Simultaneous events
//   - Input and output transfers in the same cycle keep occupancy unchanged.
//   - The pipe advances when stage 2 is empty or is draining in that cycle.
//  Reset mid-frame
//   - In-flight samples are discarded and cnt returns to 0.
//   - o_valid goes to 0 on the cycle after the rst edge.
// TESTING
//  1. Single sample i_re=0x0100, i_im=0x0040, SHIFT=6, i_ready=1
//     -> 2 cycles later o_re=0x0004, o_im=0xFFFF; o_valid pulses 1 cycle.
//  2. i_im=0x8000, i_re=0x7FFF, SHIFT=0
//     -> o_im=0x7FFF (saturated), o_re=0x7FFF.
//  3. 64 back-to-back samples, i_last on #63, i_ready=1
//     -> 64 consecutive o_valid cycles; o_last only on #63; o_frm_err=0.
//  4. Stream with i_ready toggling 1,0,0,1 during samples
//     -> no loss and no duplication; outputs stay stable while stalled;
//        o_ready drops only when both stages are full.
//  5. i_last asserted on sample #10
//     -> o_frm_err=1 from the next cycle and stays set; o_last still on #63.
//  6. rst asserted with 2 samples in flight
//     -> next cycle o_valid=0 and o_ready=1; the next frame's o_last lands
//        on its sample #63.

Source files
------------

// File: rtl/ifft_conj_post_16b.sv
// IFFT output post-processing: conjugate (negate imaginary) then 1/N scale, with frame counting.
// Latency: 2 cycles from input transfer to o_valid; 1 sample/cycle when i_ready stays high.
// Backpressure: o_ready drops only when both stages are full and downstream stalls.
module ifft_conj_post_16b #(
  parameter int N_POINTS = 64,
  parameter int SHIFT    = 6,
  parameter bit BYPASS   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_re,
  input  logic [15:0] i_im,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [15:0] o_re,
  output logic [15:0] o_im,
  output logic        o_valid,
  output logic        o_last,
  input  logic        i_ready,
  output logic        o_frm_err
);

  localparam int               CNT_W   = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_POINTS - 1);
  // Rounding constant for half-up rounding; zero when no shift is applied.
  localparam logic [16:0]      RND     = (SHIFT == 0) ? 17'd0
                                         : (17'd1 << ((SHIFT > 0) ? SHIFT - 1 : 0));

  // Negation with saturation: -(-32768) does not fit, so it clamps to +32767.
  function automatic logic [15:0] conj_im(input logic [15:0] x);
    if (x == 16'h8000) begin
      return 16'h7FFF;
    end
    return ~x + 16'd1;
  endfunction

  // Round half up, arithmetic shift right, clamp to the 16-bit signed range.
  function automatic logic [15:0] scale(input logic [15:0] x);
    logic signed [16:0] sum;
    logic signed [16:0] shd;
    sum = $signed({x[15], x}) + $signed(RND);
    shd = sum >>> SHIFT;
    if (shd[16] != shd[15]) begin
      return shd[16] ? 16'h8000 : 16'h7FFF;
    end
    return shd[15:0];
  endfunction

  logic             s1_vld_q, s1_vld_d;
  logic [15:0]      s1_re_q, s1_re_d;
  logic [15:0]      s1_im_q, s1_im_d;
  logic             s1_last_q, s1_last_d;
  logic             s2_vld_q, s2_vld_d;
  logic [15:0]      s2_re_q, s2_re_d;
  logic [15:0]      s2_im_q, s2_im_d;
  logic             s2_last_q, s2_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frm_err_q, frm_err_d;

  logic in_xfer;
  logic out_xfer;
  logic adv;
  logic cnt_at_max;

  assign o_ready    = !(s1_vld_q && s2_vld_q && !i_ready);
  assign in_xfer    = i_valid && o_ready;
  assign out_xfer   = s2_vld_q && i_ready;
  // Stage 1 moves forward when stage 2 is empty or draining this cycle.
  assign adv        = s1_vld_q && (!s2_vld_q || i_ready);
  assign cnt_at_max = (cnt_q == CNT_MAX);

  assign o_valid   = s2_vld_q;
  assign o_re      = s2_re_q;
  assign o_im      = s2_im_q;
  assign o_last    = s2_last_q;
  assign o_frm_err = frm_err_q;

  // Next-state for both pipe stages, the frame counter and the sticky error flag.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_re_d   = s1_re_q;
    s1_im_d   = s1_im_q;
    s1_last_d = s1_last_q;
    s2_vld_d  = s2_vld_q;
    s2_re_d   = s2_re_q;
    s2_im_d   = s2_im_q;
    s2_last_d = s2_last_q;
    cnt_d     = cnt_q;
    frm_err_d = frm_err_q;

    if (in_xfer) begin
      s1_vld_d  = 1'b1;
      s1_re_d   = i_re;
      s1_im_d   = BYPASS ? i_im : conj_im(i_im);
      s1_last_d = cnt_at_max;
      cnt_d     = cnt_at_max ? '0 : cnt_q + 1'b1;
      // A misplaced i_last only raises the flag; the counter keeps its own phase.
      if (i_last != cnt_at_max) begin
        frm_err_d = 1'b1;
      end
    end else if (adv) begin
      s1_vld_d = 1'b0;
    end

    if (adv) begin
      s2_vld_d  = 1'b1;
      s2_re_d   = BYPASS ? s1_re_q : scale(s1_re_q);
      s2_im_d   = BYPASS ? s1_im_q : scale(s1_im_q);
      s2_last_d = s1_last_q;
    end else if (out_xfer) begin
      s2_vld_d = 1'b0;
    end
  end

  // State registers; reset empties the pipe and clears outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_re_q   <= '0;
      s2_im_q   <= '0;
      s2_last_q <= 1'b0;
      cnt_q     <= '0;
      frm_err_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_re_q   <= s1_re_d;
      s1_im_q   <= s1_im_d;
      s1_last_q <= s1_last_d;
      s2_vld_q  <= s2_vld_d;
      s2_re_q   <= s2_re_d;
      s2_im_q   <= s2_im_d;
      s2_last_q <= s2_last_d;
      cnt_q     <= cnt_d;
      frm_err_q <= frm_err_d;
    end
  end

endmodule

// File: tb/tb_ifft_conj_post_16b.sv
// Bench for ifft_conj_post_16b: directed vectors, scoreboard for streams.
// Three instances share inputs: SHIFT=6, SHIFT=0 and BYPASS=1.
// i_ready is driven either high or from a repeating stall pattern.
module tb_ifft_conj_post_16b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_re = '0;
  logic [15:0] i_im = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        i_ready = 1'b1;

  logic        o_ready, o_valid, o_last, o_frm_err;
  logic [15:0] o_re, o_im;
  logic        s0_ready, s0_valid, s0_last, s0_frm_err;
  logic [15:0] s0_re, s0_im;
  logic        by_ready, by_valid, by_last, by_frm_err;
  logic [15:0] by_re, by_im;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ifft_conj_post_16b #(.N_POINTS(64), .SHIFT(6), .BYPASS(1'b0)) dut (
    .clk(clk), .rst(rst), .i_re(i_re), .i_im(i_im), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_re(o_re), .o_im(o_im), .o_valid(o_valid), .o_last(o_last),
    .i_ready(i_ready), .o_frm_err(o_frm_err));

  ifft_conj_post_16b #(.N_POINTS(64), .SHIFT(0), .BYPASS(1'b0)) dut_s0 (
    .clk(clk), .rst(rst), .i_re(i_re), .i_im(i_im), .i_valid(i_valid), .i_last(i_last),
    .o_ready(s0_ready), .o_re(s0_re), .o_im(s0_im), .o_valid(s0_valid), .o_last(s0_last),
    .i_ready(i_ready), .o_frm_err(s0_frm_err));

  ifft_conj_post_16b #(.N_POINTS(64), .SHIFT(6), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .i_re(i_re), .i_im(i_im), .i_valid(i_valid), .i_last(i_last),
    .o_ready(by_ready), .o_re(by_re), .o_im(by_im), .o_valid(by_valid), .o_last(by_last),
    .i_ready(i_ready), .o_frm_err(by_frm_err));

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: saturating negate, and (x+32)>>>6 in integer arithmetic.
  function automatic logic [15:0] m_conj(input logic [15:0] x);
    int v;
    v = $signed(x);
    v = (v == -32768) ? 32767 : -v;
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_scale(input logic [15:0] x);
    int v;
    v = $signed(x);
    v = (v + 32) >>> 6;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  // i_ready driver: constant high, or the 1,0,0,1 stall pattern.
  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  int         pidx     = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      i_ready = rdy_pat[pidx];
      pidx    = (pidx + 1) % 4;
    end else begin
      i_ready = 1'b1;
    end
  end

  // Monitor: scoreboard, occupancy model, stall hold and frame-error tracking.
  logic [32:0] sb[$];
  logic [32:0] e;
  logic [32:0] prev_out;
  logic        prev_stall;
  logic        exp_err;
  logic        last_e;
  int          occ, cnt, out_cnt, first_out, last_out, cyc;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      occ        = 0;
      cnt        = 0;
      out_cnt    = 0;
      exp_err    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("o_ready", {39'd0, o_ready}, {39'd0, !(occ == 2 && !i_ready)});
      chk("frm_err", {39'd0, o_frm_err}, {39'd0, exp_err});
      if (prev_stall) begin
        chk("hold_valid", {39'd0, o_valid}, 40'd1);
        chk("hold_data", {7'd0, o_last, o_re, o_im}, {7'd0, prev_out});
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("out_without_in", {39'd0, o_valid}, 40'd0);
        end else begin
          e = sb.pop_front();
          chk("out_data", {7'd0, o_last, o_re, o_im}, {7'd0, e});
          out_cnt++;
          if (out_cnt == 1) first_out = cyc;
          last_out = cyc;
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = {o_last, o_re, o_im};
      if (i_valid && o_ready) begin
        last_e = (cnt == 63);
        sb.push_back({last_e, m_scale(i_re), m_scale(m_conj(i_im))});
        if (i_last != last_e) exp_err = 1'b1;
        cnt = (cnt == 63) ? 0 : cnt + 1;
      end
      occ = occ + int'(i_valid && o_ready) - int'(o_valid && i_ready);
    end
  end

  // Presents one sample and waits (bounded) for it to be accepted.
  // Called and returns at posedge+1.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    bit done = 1'b0;
    i_valid = 1'b1;
    i_re    = re;
    i_im    = im;
    i_last  = last;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (o_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", {39'd0, o_ready}, 40'd1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    i_valid  = 1'b0;
    i_last   = 1'b0;
    rdy_mode = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && occ == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 40'(sb.size()), 40'd0);
  endtask

  task automatic frame(input int n, input int last_idx);
    logic [15:0] re, im;
    for (int k = 0; k < n; k++) begin
      re = 16'(k * 1237 - 20000);
      im = (k % 7 == 0) ? 16'h8000 : 16'(k * 2741 + 3);
      send(re, im, k == last_idx);
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", {39'd0, o_valid}, 40'd0);
    chk("rst_ready", {39'd0, o_ready}, 40'd1);
    chk("rst_data", {7'd0, o_last, o_re, o_im}, 40'd0);
    chk("rst_err", {39'd0, o_frm_err}, 40'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: single sample, 2-cycle latency, 1-cycle o_valid pulse
    send(16'h0100, 16'h0040, 1'b0);
    i_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_early", {39'd0, o_valid}, 40'd0);
    @(negedge clk);
    chk("t1_valid", {39'd0, o_valid}, 40'd1);
    chk("t1_re", {24'd0, o_re}, 40'h0004);
    chk("t1_im", {24'd0, o_im}, 40'hFFFF);
    chk("t1_s0_re", {24'd0, s0_re}, 40'h0100);
    chk("t1_s0_im", {24'd0, s0_im}, 40'hFFC0);
    chk("t1_byp_valid", {39'd0, by_valid}, 40'd1);
    chk("t1_byp_re", {24'd0, by_re}, 40'h0100);
    chk("t1_byp_im", {24'd0, by_im}, 40'h0040);
    @(negedge clk);
    chk("t1_valid_pulse", {39'd0, o_valid}, 40'd0);
    @(posedge clk);
    #1;

    // Test 2: saturating negate of 0x8000
    send(16'h7FFF, 16'h8000, 1'b0);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_s0_valid", {39'd0, s0_valid}, 40'd1);
    chk("t2_s0_re", {24'd0, s0_re}, 40'h7FFF);
    chk("t2_s0_im", {24'd0, s0_im}, 40'h7FFF);
    chk("t2_re", {24'd0, o_re}, 40'h0200);
    chk("t2_im", {24'd0, o_im}, 40'h0200);
    chk("t2_byp_im", {24'd0, by_im}, 40'h8000);
    @(posedge clk);
    #1;
    drain();

    // Test 3: full frame back-to-back
    do_reset();
    frame(64, 63);
    drain();
    chk("t3_out_count", 40'(out_cnt), 40'd64);
    chk("t3_consecutive", 40'(last_out - first_out), 40'd63);
    chk("t3_frm_err", {39'd0, o_frm_err}, 40'd0);

    // Test 4: stalls from the 1,0,0,1 i_ready pattern
    do_reset();
    rdy_mode = 1'b1;
    frame(20, 63);
    drain();
    chk("t4_out_count", 40'(out_cnt), 40'd20);

    // Test 5: misplaced i_last on sample #10
    do_reset();
    frame(64, 10);
    drain();
    chk("t5_frm_err", {39'd0, o_frm_err}, 40'd1);
    chk("t5_out_count", 40'(out_cnt), 40'd64);

    // Test 6: reset with two samples in flight
    send(16'h1234, 16'h0010, 1'b0);
    send(16'h2345, 16'h0020, 1'b0);
    do_reset();
    @(negedge clk);
    chk("t6_valid", {39'd0, o_valid}, 40'd0);
    chk("t6_ready", {39'd0, o_ready}, 40'd1);
    chk("t6_err_clr", {39'd0, o_frm_err}, 40'd0);
    @(posedge clk);
    #1;
    frame(64, 63);
    drain();
    chk("t6_out_count", 40'(out_cnt), 40'd64);
    chk("t6_frm_err", {39'd0, o_frm_err}, 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
